// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and a constant-evaluable ceil(log2) helper.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 16;

    // Smallest n such that 2**n >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; occupancy tracking lives in the top.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Store the incoming word at the write address on an accepted write.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with status flags, sticky error flags,
// synchronous flush and a selectable standard / first-word-fall-through read.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = clog2(DEPTH),
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  full_q, empty_q, af_q, ae_q;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  rd_accept_s;
    logic                  wr_accept_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    // A read needs a stored word; a write needs room, or a read freeing a slot
    // in the same cycle. Flush suppresses both.
    assign rd_accept_s = rd_en & ~flush & ~empty_q;
    assign wr_accept_s = wr_en & ~flush & (~full_q | rd_accept_s);

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk      (clk),
        .wr_en_i  (wr_accept_s),
        .wr_addr_i(wr_ptr_q),
        .wr_data_i(data_in),
        .rd_addr_i(rd_ptr_q),
        .rd_data_o(rd_data_s)
    );

    // Next-state for pointers, occupancy, read register and sticky errors.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        overflow_d  = overflow_q | (wr_en & ~flush & ~wr_accept_s);
        underflow_d = underflow_q | (rd_en & ~flush & empty_q);
        if (flush) begin
            wr_ptr_d = {ADDR_WIDTH{1'b0}};
            rd_ptr_d = {ADDR_WIDTH{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (wr_accept_s) begin
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_accept_s) begin
                rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_accept_s, rd_accept_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            // The head is read before the edge, so a write into the same
            // slot when full cannot corrupt the word being returned.
            if (rd_accept_s && (FWFT == 0)) begin
                dout_d = rd_data_s;
            end else begin
                dout_d = dout_q;
            end
        end
    end

    // State registers; flags are registered from next occupancy so they
    // change in the same cycle as count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= {ADDR_WIDTH{1'b0}};
            rd_ptr_q    <= {ADDR_WIDTH{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            dout_q      <= {DATA_WIDTH{1'b0}};
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            full_q      <= (count_d == DEPTH_C);
            empty_q     <= (count_d == {CNT_W{1'b0}});
            af_q        <= (count_d >= AF_C);
            ae_q        <= (count_d <= AE_C);
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // In FWFT mode the head word is presented directly; it is forced to zero
    // while empty so reset leaves a defined value on the bus.
    assign data_out     = (FWFT != 0) ? (empty_q ? {DATA_WIDTH{1'b0}} : rd_data_s)
                                      : dout_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    // standard-read instance
    logic       s_wr, s_rd, s_flush;
    logic [7:0] s_din, s_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [3:0] s_count;
    // first-word-fall-through instance
    logic       f_wr, f_rd, f_flush;
    logic [7:0] f_din, f_dout;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [3:0] f_count;

    int errors = 0;
    int checks = 0;

    // scoreboard and model state for the standard instance
    logic [7:0] sb[$];
    logic [7:0] fsb[$];
    int         mcnt;
    logic       movf, munf;
    logic       rd_acc;
    logic [7:0] held;
    logic [7:0] exp_v;

    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(s_wr), .data_in(s_din), .rd_en(s_rd),
        .flush(s_flush), .data_out(s_dout), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(f_wr), .data_in(f_din), .rd_en(f_rd),
        .flush(f_flush), .data_out(f_dout), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    // Drive one cycle on the standard FIFO and advance the reference model.
    task automatic step_std(input logic w, input logic r, input logic [7:0] d, input logic fl);
        logic wacc, racc;
        racc = r && !fl && (mcnt > 0);
        wacc = w && !fl && ((mcnt < 8) || racc);
        if (w && !fl && !wacc) movf = 1'b1;
        if (r && !fl && (mcnt == 0)) munf = 1'b1;
        s_wr = w; s_rd = r; s_din = d; s_flush = fl;
        if (fl) begin
            sb.delete();
            mcnt = 0;
        end else begin
            if (wacc) sb.push_back(d);
            if (wacc && !racc) mcnt = mcnt + 1;
            if (racc && !wacc) mcnt = mcnt - 1;
        end
        @(posedge clk);
        #1;
        rd_acc = racc;
        s_wr = 1'b0; s_rd = 1'b0; s_flush = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (s_count !== 4'd0 || s_empty !== 1'b1 || s_ae !== 1'b1 || s_full !== 1'b0 ||
            s_af !== 1'b0 || s_ovf !== 1'b0 || s_unf !== 1'b0 || s_dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_std: cnt=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b d=%h required 0 1 1 0 0 0 0 00",
                     s_count, s_empty, s_ae, s_full, s_af, s_ovf, s_unf, s_dout);
        end
        checks++;
        if (f_count !== 4'd0 || f_empty !== 1'b1 || f_ae !== 1'b1 || f_dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_fwft: cnt=%0d e=%b ae=%b d=%h required 0 1 1 00",
                     f_count, f_empty, f_ae, f_dout);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            step_std(1'b1, 1'b0, 8'(i), 1'b0);
            checks++;
            if (s_count !== 4'(i) || s_af !== (i >= 6) || s_ae !== (i <= 2) ||
                s_full !== (i == 8) || s_empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d: cnt=%0d af=%b ae=%b full=%b empty=%b required cnt=%0d af=%b ae=%b full=%b empty=0",
                         i, s_count, s_af, s_ae, s_full, s_empty, i, (i >= 6), (i <= 2), (i == 8));
            end
        end
        step_std(1'b1, 1'b0, 8'h99, 1'b0);
        checks++;
        if (s_ovf !== 1'b1 || s_count !== 4'd8 || s_full !== 1'b1) begin
            errors++;
            $display("FAIL overflow: ov=%b cnt=%0d full=%b required 1 8 1", s_ovf, s_count, s_full);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            step_std(1'b0, 1'b1, 8'h00, 1'b0);
            if (rd_acc) begin
                exp_v = sb.pop_front();
                held  = exp_v;
                checks++;
                if (s_dout !== exp_v || exp_v !== 8'(i)) begin
                    errors++;
                    $display("FAIL drain_data_%0d: got %h required %h", i, s_dout, 8'(i));
                end
            end
            checks++;
            if (s_count !== 4'(8 - i) || s_ae !== ((8 - i) <= 2)) begin
                errors++;
                $display("FAIL drain_cnt_%0d: cnt=%0d ae=%b required %0d %b", i, s_count, s_ae, 8 - i, ((8 - i) <= 2));
            end
        end
        step_std(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (s_dout !== 8'h08) begin
            errors++;
            $display("FAIL hold_data: got %h required 08", s_dout);
        end
        step_std(1'b1 & 1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (s_unf !== 1'b1 || s_empty !== 1'b1 || s_dout !== 8'h08 || s_count !== 4'd0) begin
            errors++;
            $display("FAIL underflow: un=%b empty=%b d=%h cnt=%0d required 1 1 08 0", s_unf, s_empty, s_dout, s_count);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) step_std(1'b1, 1'b0, 8'(i), 1'b0);
        for (int k = 0; k < 4; k++) begin
            step_std(1'b1, 1'b1, 8'(9 + k), 1'b0);
            exp_v = sb.pop_front();
            held  = exp_v;
            checks++;
            if (s_dout !== 8'(k + 1) || s_count !== 4'd8 || s_full !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%0d: d=%h cnt=%0d full=%b required %h 8 1", k, s_dout, s_count, s_full, 8'(k + 1));
            end
        end
        for (int i = 5; i <= 12; i++) begin
            step_std(1'b0, 1'b1, 8'h00, 1'b0);
            exp_v = sb.pop_front();
            held  = exp_v;
            checks++;
            if (s_dout !== exp_v || exp_v !== 8'(i)) begin
                errors++;
                $display("FAIL b2b_tail_%0d: got %h required %h", i, s_dout, 8'(i));
            end
        end
        checks++;
        if (s_empty !== 1'b1 || s_count !== 4'd0) begin
            errors++;
            $display("FAIL b2b_empty: empty=%b cnt=%0d required 1 0", s_empty, s_count);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) step_std(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        step_std(1'b1, 1'b1, 8'hEE, 1'b1);
        checks++;
        if (s_count !== 4'd0 || s_empty !== 1'b1 || s_dout !== held ||
            s_ovf !== movf || s_unf !== munf) begin
            errors++;
            $display("FAIL flush: cnt=%0d empty=%b d=%h ov=%b un=%b required 0 1 %h %b %b",
                     s_count, s_empty, s_dout, s_ovf, s_unf, held, movf, munf);
        end
        step_std(1'b1, 1'b0, 8'h3C, 1'b0);
        step_std(1'b0, 1'b1, 8'h00, 1'b0);
        if (rd_acc) begin
            exp_v = sb.pop_front();
            held  = exp_v;
        end
        checks++;
        if (s_dout !== 8'h3C || !rd_acc) begin
            errors++;
            $display("FAIL flush_reuse: got %h required 3c", s_dout);
        end
    endtask

    task automatic test_fwft();
        f_wr = 1'b1; f_din = 8'hA5;
        @(posedge clk); #1;
        f_wr = 1'b0;
        checks++;
        if (f_empty !== 1'b0 || f_dout !== 8'hA5) begin
            errors++;
            $display("FAIL fwft_first: empty=%b d=%h required 0 a5", f_empty, f_dout);
        end
        f_rd = 1'b1;
        @(posedge clk); #1;
        f_rd = 1'b0;
        checks++;
        if (f_empty !== 1'b1 || f_count !== 4'd0) begin
            errors++;
            $display("FAIL fwft_pop: empty=%b cnt=%0d required 1 0", f_empty, f_count);
        end
        for (int i = 1; i <= 3; i++) begin
            f_wr = 1'b1; f_din = 8'(8'h11 * i);
            fsb.push_back(8'(8'h11 * i));
            @(posedge clk); #1;
        end
        f_wr = 1'b0;
        while (fsb.size() > 0) begin
            exp_v = fsb.pop_front();
            checks++;
            if (f_dout !== exp_v || f_empty !== 1'b0) begin
                errors++;
                $display("FAIL fwft_head: got %h empty=%b required %h 0", f_dout, f_empty, exp_v);
            end
            f_rd = 1'b1;
            @(posedge clk); #1;
            f_rd = 1'b0;
        end
        checks++;
        if (f_empty !== 1'b1 || f_ovf !== 1'b0 || f_unf !== 1'b0) begin
            errors++;
            $display("FAIL fwft_end: empty=%b ov=%b un=%b required 1 0 0", f_empty, f_ovf, f_unf);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) step_std(1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
        step_std(1'b0, 1'b1, 8'h00, 1'b0);
        if (rd_acc) exp_v = sb.pop_front();
        s_wr = 1'b1; s_din = 8'h66;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (s_count !== 4'd0 || s_empty !== 1'b1 || s_ae !== 1'b1 || s_full !== 1'b0 ||
            s_af !== 1'b0 || s_ovf !== 1'b0 || s_unf !== 1'b0 || s_dout !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: cnt=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b d=%h required 0 1 1 0 0 0 0 00",
                     s_count, s_empty, s_ae, s_full, s_af, s_ovf, s_unf, s_dout);
        end
        s_wr = 1'b0;
        sb.delete(); mcnt = 0; movf = 1'b0; munf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        step_std(1'b1, 1'b0, 8'h77, 1'b0);
        step_std(1'b0, 1'b1, 8'h00, 1'b0);
        if (rd_acc) exp_v = sb.pop_front();
        checks++;
        if (s_dout !== 8'h77 || s_empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: d=%h empty=%b required 77 1", s_dout, s_empty);
        end
    endtask

    initial begin
        rst = 1'b1;
        s_wr = 1'b0; s_rd = 1'b0; s_flush = 1'b0; s_din = 8'h00;
        f_wr = 1'b0; f_rd = 1'b0; f_flush = 1'b0; f_din = 8'h00;
        mcnt = 0; movf = 1'b0; munf = 1'b0; rd_acc = 1'b0; held = 8'h00; exp_v = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_fwft();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
